// File: rtl/mss_uart_rx_buffer.sv
// 8N1 UART receiver with a first-word-fall-through receive FIFO and sticky
// framing/overrun flags, fed from the MSS MMUART_0 transmit line.
module mss_uart_rx_buffer #(
  parameter int BAUD_DIV   = 434,
  parameter int FIFO_DEPTH = 16,
  localparam int CW        = $clog2(FIFO_DEPTH + 1)
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          UART_RXD,
  output logic [7:0]    RX_DATA,
  output logic          RX_VALID,
  input  logic          RX_READY,
  output logic [CW-1:0] FIFO_COUNT,
  output logic          FRAME_ERR,
  output logic          OVERRUN,
  input  logic          ERR_CLR
);

  localparam int BW = $clog2(BAUD_DIV);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [BW-1:0] HALF_LOAD = BW'(BAUD_DIV / 2 - 1);
  localparam logic [BW-1:0] FULL_LOAD = BW'(BAUD_DIV - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_STOP  = 3'd3;
  localparam logic [2:0] S_BRK   = 3'd4;

  logic          sync1_q, rxs_q;
  logic [2:0]    state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          baud_zero, push_req, fe_set;

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    last_q;
  logic          fe_q, ov_q;
  logic          pop, full, push_ok, ov_set;

  // Line idles high, so the synchronizer presets to 1 to avoid a false start.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      sync1_q <= 1'b1;
      rxs_q   <= 1'b1;
    end else begin
      sync1_q <= UART_RXD;
      rxs_q   <= sync1_q;
    end
  end

  assign baud_zero = (baud_q == '0);

  always_comb begin
    state_d  = state_q;
    baud_d   = baud_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    push_req = 1'b0;
    fe_set   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!rxs_q) begin
          state_d = S_START;
          baud_d  = HALF_LOAD;
        end
      end
      S_START: begin
        if (!baud_zero) begin
          baud_d = baud_q - BW'(1);
        end else if (!rxs_q) begin
          state_d = S_DATA;
          baud_d  = FULL_LOAD;
          bit_d   = 3'd0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_DATA: begin
        if (!baud_zero) begin
          baud_d = baud_q - BW'(1);
        end else begin
          shift_d = {rxs_q, shift_q[7:1]};
          baud_d  = FULL_LOAD;
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (!baud_zero) begin
          baud_d = baud_q - BW'(1);
        end else if (rxs_q) begin
          push_req = 1'b1;
          state_d  = S_IDLE;
        end else begin
          fe_set  = 1'b1;
          state_d = S_BRK;
        end
      end
      S_BRK: begin
        // A held-low line must return high before another start is accepted.
        if (rxs_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      bit_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
    end
  end

  always_ff @(posedge CLK) shift_q <= shift_d;

  // A pop in the push cycle frees a slot, so a full FIFO still accepts the byte.
  assign pop     = RX_READY && (cnt_q != '0);
  assign full    = (cnt_q == CW'(FIFO_DEPTH));
  assign push_ok = push_req && (!full || pop);
  assign ov_set  = push_req && full && !pop;

  always_comb begin
    cnt_d = cnt_q;
    if (push_ok && !pop)      cnt_d = cnt_q + CW'(1);
    else if (!push_ok && pop) cnt_d = cnt_q - CW'(1);
  end

  always_ff @(posedge CLK) begin
    if (push_ok) mem_q[wr_q] <= shift_q;
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      wr_q   <= '0;
      rd_q   <= '0;
      cnt_q  <= '0;
      last_q <= 8'h00;
      fe_q   <= 1'b0;
      ov_q   <= 1'b0;
    end else begin
      if (push_ok) wr_q <= wr_q + AW'(1);
      if (pop) begin
        rd_q   <= rd_q + AW'(1);
        last_q <= mem_q[rd_q];
      end
      cnt_q <= cnt_d;
      fe_q  <= fe_set || (fe_q && !ERR_CLR);
      ov_q  <= ov_set || (ov_q && !ERR_CLR);
    end
  end

  // When empty, RX_DATA keeps showing the most recently popped byte.
  assign RX_DATA    = (cnt_q != '0) ? mem_q[rd_q] : last_q;
  assign RX_VALID   = (cnt_q != '0);
  assign FIFO_COUNT = cnt_q;
  assign FRAME_ERR  = fe_q;
  assign OVERRUN    = ov_q;

endmodule
